warp_multiskid: RTL

WARP_MULTISKID -- requirements
Module: warp_multiskid

---
 rtl/warp_multiskid.sv | 119 +++++++++++
 1 files changed

// File: rtl/warp_multiskid.sv
// warp_multiskid: multi-lane in-order circular buffer (skid buffer).
//   Up to LANES entries are written and up to LANES read per cycle.
//   Capacity and read count are registered from the next occupancy, so
//   neither depends combinationally on i_rtake or i_wcount.
// Ports:
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_flush              synchronous discard of all contents
//   i_wcount, i_wdata    lanes 0..i_wcount-1 offered for write
//   o_wcapacity          lanes accepted this cycle (registered)
//   o_rcount, o_rdata    valid output lanes 0..o_rcount-1, lane 0 oldest
//   i_rtake              lanes consumed this cycle (clamped to o_rcount)
//   o_occupancy          entries stored (registered)

// Per-lane address / write-enable generation.
module warp_multiskid_lane #(
  parameter int LANE = 0,
  parameter int CW   = 2,
  parameter int AW   = 2
) (
  input  logic [AW-1:0] i_head,
  input  logic [AW-1:0] i_tail,
  input  logic [CW-1:0] i_wacc,
  input  logic          i_flush,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [AW-1:0] o_raddr
);
  assign o_we    = !i_flush && (i_wacc > CW'(LANE));
  assign o_waddr = i_tail + AW'(LANE);  // wraps modulo DEPTH
  assign o_raddr = i_head + AW'(LANE);
endmodule

module warp_multiskid #(
  parameter int WIDTH = 32,
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(LANES+1),
  localparam int OW = $clog2(DEPTH+1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic [CW-1:0]          i_wcount,
  input  logic [LANES*WIDTH-1:0] i_wdata,
  output logic [CW-1:0]          o_wcapacity,
  output logic [CW-1:0]          o_rcount,
  output logic [LANES*WIDTH-1:0] o_rdata,
  input  logic [CW-1:0]          i_rtake,
  output logic [OW-1:0]          o_occupancy
);
  localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);
  localparam logic [OW-1:0] LANES_O = OW'(LANES);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head, r_tail;
  logic [OW-1:0]    r_occ;
  logic [CW-1:0]    r_wcap, r_rcnt;

  logic [CW-1:0]    w_wacc, w_racc, w_next_wcap, w_next_rcnt;
  logic [OW-1:0]    w_next_occ, w_room;
  logic [LANES-1:0]         w_we;
  logic [LANES-1:0][AW-1:0] w_waddr, w_raddr;

  // r_wcap/r_rcnt already bound both to LANES, so these mins also clamp
  // out-of-range requests.
  assign w_wacc     = (i_wcount < r_wcap) ? i_wcount : r_wcap;
  assign w_racc     = (i_rtake  < r_rcnt) ? i_rtake  : r_rcnt;
  assign w_next_occ = r_occ + OW'(w_wacc) - OW'(w_racc);
  assign w_room     = DEPTH_O - w_next_occ;
  assign w_next_wcap = (w_room     < LANES_O) ? CW'(w_room)     : CW'(LANES);
  assign w_next_rcnt = (w_next_occ < LANES_O) ? CW'(w_next_occ) : CW'(LANES);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    warp_multiskid_lane #(.LANE(k), .CW(CW), .AW(AW)) u_lane (
      .i_head  (r_head),
      .i_tail  (r_tail),
      .i_wacc  (w_wacc),
      .i_flush (i_flush),
      .o_we    (w_we[k]),
      .o_waddr (w_waddr[k]),
      .o_raddr (w_raddr[k])
    );
    // Read mux driven only from registered pointer and memory.
    assign o_rdata[k*WIDTH +: WIDTH] = r_mem[w_raddr[k]];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_rcnt <= '0;
      r_wcap <= CW'(LANES);
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // w_we is already gated by flush, so flushed writes never land.
      for (int k = 0; k < LANES; k++)
        if (w_we[k]) r_mem[w_waddr[k]] <= i_wdata[k*WIDTH +: WIDTH];
      if (i_flush) begin
        r_head <= '0;
        r_tail <= '0;
        r_occ  <= '0;
        r_rcnt <= '0;
        r_wcap <= CW'(LANES);
      end else begin
        r_head <= r_head + AW'(w_racc);
        r_tail <= r_tail + AW'(w_wacc);
        r_occ  <= w_next_occ;
        r_rcnt <= w_next_rcnt;
        r_wcap <= w_next_wcap;
      end
    end
  end

  assign o_wcapacity = r_wcap;
  assign o_rcount    = r_rcnt;
  assign o_occupancy = r_occ;
endmodule
